// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: FSM states, halt code, branch targets.
// Also read by assembler-facing tests.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } fetch_state_e;

  localparam logic [8:0] HALT_CODE = 9'h1FF;

  localparam int TGT_W = 10;
  localparam int LUT_N = 8;

  localparam logic [TGT_W-1:0] BR_LUT [LUT_N] = '{
    10'd10,
    10'd20,
    10'd40,
    10'd100,
    10'd200,
    10'd300,
    10'd500,
    10'd1023
  };

  // Indices past the table read as 0.
  function automatic logic [TGT_W-1:0] br_target(
    input logic [31:0] i
  );
    if (i < 32'(LUT_N)) return BR_LUT[i[2:0]];
    return '0;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Constant branch-target ROM, purely combinational.
// Ports: tgt_idx (LUT_W) in, target (PC_W) out.
module branch_lut #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 3
) (
  input  logic [LUT_W-1:0] tgt_idx,
  output logic [PC_W-1:0]  target
);
  import instr_fetch_pkg::*;

  assign target = PC_W'(br_target(32'(tgt_idx)));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, next-PC mux and IDLE/RUN/HALT FSM.
// Ports: clk, reset, start, stall, branch, taken, tgt_idx, mach_code in; prog_ctr, running, done out.
module instr_fetch #(
  parameter int         PC_W      = 10,
  parameter int         LUT_W     = 3,
  parameter logic [8:0] HALT_CODE = instr_fetch_pkg::HALT_CODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch,
  input  logic             taken,
  input  logic [LUT_W-1:0] tgt_idx,
  input  logic [8:0]       mach_code,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             running,
  output logic             done
);
  import instr_fetch_pkg::*;

  localparam logic [PC_W-1:0] PC_MAX = '1;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_tgt;

  branch_lut #(
    .PC_W (PC_W),
    .LUT_W(LUT_W)
  ) u_lut (
    .tgt_idx(tgt_idx),
    .target (lut_tgt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (!stall) begin
          // Halt wins over branch; the last word halts instead of wrapping.
          if (mach_code == HALT_CODE) begin
            state_d = S_HALT;
          end else if (branch && taken) begin
            pc_d = lut_tgt;
          end else if (pc_q == PC_MAX) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign prog_ctr = pc_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// Ports of the DUT driven from one linear initial block.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch, taken;
  logic [2:0] tgt_idx;
  logic [8:0] mach_code;
  logic [9:0] prog_ctr;
  logic       running, done;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall),
    .branch   (branch),
    .taken    (taken),
    .tgt_idx  (tgt_idx),
    .mach_code(mach_code),
    .prog_ctr (prog_ctr),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic [31:0] pc,
                        input logic r,
                        input logic d);
    chk({tag, "_pc"}, 32'(prog_ctr), pc);
    chk({tag, "_run"}, 32'(running), 32'(r));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask

  initial begin
    reset = 1; start = 0; stall = 0;
    branch = 0; taken = 0; tgt_idx = 0;
    mach_code = 9'h000;
    step();
    chk_st("reset", 0, 0, 0);
    reset = 0;
    step();
    chk_st("idle", 0, 0, 0);

    start = 1;
    step();
    start = 0;
    chk_st("start", 0, 1, 0);
    step(); chk_st("seq1", 1, 1, 0);
    step(); chk_st("seq2", 2, 1, 0);
    step(); chk_st("seq3", 3, 1, 0);
    step(); step();
    chk_st("seq5", 5, 1, 0);

    branch = 1; taken = 1; tgt_idx = 2;
    step();
    chk_st("br_taken", 40, 1, 0);
    branch = 0; taken = 0;

    // Back to PC 5 for the not-taken case.
    reset = 1; step(); reset = 0;
    start = 1; step(); start = 0;
    repeat (5) step();
    chk("at5", 32'(prog_ctr), 5);
    branch = 1; taken = 0; tgt_idx = 2;
    step();
    chk_st("br_not_taken", 6, 1, 0);
    branch = 0;
    step();
    chk("at7", 32'(prog_ctr), 7);

    stall = 1; branch = 1; taken = 1; tgt_idx = 2;
    step(); chk_st("stall1", 7, 1, 0);
    step(); chk_st("stall2", 7, 1, 0);
    step(); chk_st("stall3", 7, 1, 0);
    stall = 0;
    step();
    chk_st("stall_rel", 40, 1, 0);

    branch = 0; taken = 1;
    step();
    chk("taken_no_br", 32'(prog_ctr), 41);

    branch = 1; tgt_idx = 0;
    step();
    chk("br_to10", 32'(prog_ctr), 10);
    branch = 0; taken = 0;
    step(); step();
    chk("at12", 32'(prog_ctr), 12);

    // Halt beats a taken branch.
    mach_code = 9'h1FF; branch = 1; taken = 1; tgt_idx = 2;
    step();
    chk_st("halt", 12, 0, 1);
    branch = 0; taken = 0;
    step();
    chk_st("halt_hold", 12, 0, 1);
    mach_code = 9'h000;
    start = 1;
    step();
    start = 0;
    chk_st("restart", 0, 1, 0);

    start = 1;
    step();
    start = 0;
    chk_st("start_in_run", 1, 1, 0);

    branch = 1; taken = 1; tgt_idx = 7;
    step();
    chk_st("to_max", 1023, 1, 0);
    branch = 0; taken = 0;
    step();
    chk_st("no_wrap", 1023, 0, 1);
    step();
    chk_st("no_wrap_hold", 1023, 0, 1);

    start = 1; step(); start = 0;
    branch = 1; taken = 1; tgt_idx = 1;
    step();
    chk_st("at20", 20, 1, 0);
    reset = 1; start = 1; stall = 1;
    step();
    chk_st("mid_reset", 0, 0, 0);
    reset = 0; start = 0; stall = 0;
    branch = 0; taken = 0;
    step();
    chk_st("post_reset", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
